// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and sizing constants for the writeback arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned ROB_IDX_LEN    = 5;
  localparam int unsigned NUM_CDB_INPUTS = 2;
  localparam int unsigned XLEN           = 32;

  // One completed result headed for the CDB.
  typedef struct packed {
    logic [ROB_IDX_LEN-1:0] rob;
    logic [XLEN-1:0]        data;
  } cdb_result_t;

  // One CDB lane as seen by reservation stations and the ROB.
  typedef struct packed {
    logic        vld;
    cdb_result_t result;
  } cdb_lane_t;

  typedef struct packed {
    cdb_lane_t [NUM_CDB_INPUTS-1:0] data_lanes;
  } common_data_bus_t;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Writeback requesters on one side, CDB lanes on the other.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 6,
  parameter int unsigned NUM_LANES = NUM_CDB_INPUTS
);

  localparam int unsigned ROB_W = ROB_IDX_LEN;
  localparam int unsigned SRC_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]                   req_vld_i;
  logic [NUM_REQ-1:0]                   req_rdy_o;
  logic [NUM_REQ-1:0][ROB_W-1:0]        req_rob_i;
  logic [NUM_REQ-1:0][XLEN-1:0]         req_data_i;
  logic [NUM_LANES-1:0]                 lane_vld_o;
  logic [NUM_LANES-1:0][ROB_W-1:0]      lane_rob_o;
  logic [NUM_LANES-1:0][XLEN-1:0]       lane_data_o;
  logic [NUM_LANES-1:0][SRC_W-1:0]      lane_src_o;

  // Functional units / consumers side.
  modport master (
    output req_vld_i, req_rob_i, req_data_i,
    input  req_rdy_o, lane_vld_o, lane_rob_o, lane_data_o, lane_src_o
  );

  // Arbiter side.
  modport slave (
    input  req_vld_i, req_rob_i, req_data_i,
    output req_rdy_o, lane_vld_o, lane_rob_o, lane_data_o, lane_src_o
  );

endinterface

// File: rtl/cdb_arbiter_rr_multi_grant.sv
// Round-robin scan granting up to NUM_LANES requests per cycle, in scan order.
module cdb_arbiter_rr_multi_grant
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 6,
  parameter int unsigned NUM_LANES = 2,
  localparam int unsigned PTR_W    = idx_w(NUM_REQ),
  localparam int unsigned LANE_W   = idx_w(NUM_LANES)
) (
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [PTR_W-1:0]                    ptr,
  output logic [NUM_REQ-1:0]                  grant_c,
  output logic [NUM_LANES-1:0][NUM_REQ-1:0]   lane_sel_c,
  output logic [NUM_LANES-1:0]                lane_vld_c,
  output logic [PTR_W-1:0]                    nxt_ptr_c
);

  // Walk ptr, ptr+1, ... modulo NUM_REQ; k-th hit lands on lane k.
  always_comb begin
    int unsigned idx;
    int unsigned cnt;
    int unsigned last;
    grant_c    = '0;
    lane_sel_c = '0;
    lane_vld_c = '0;
    nxt_ptr_c  = ptr;
    idx        = 0;
    cnt        = 0;
    last       = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[PTR_W'(idx)] && (cnt < NUM_LANES)) begin
        grant_c[PTR_W'(idx)]                     = 1'b1;
        lane_sel_c[LANE_W'(cnt)][PTR_W'(idx)]    = 1'b1;
        lane_vld_c[LANE_W'(cnt)]                 = 1'b1;
        cnt                                      = cnt + 1;
        last                                     = idx;
      end
    end
    // Resume just past the last winner so nobody is passed over twice.
    if (cnt != 0) nxt_ptr_c = ((last + 1) == NUM_REQ) ? '0 : PTR_W'(last + 1);
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per writeback port,
// round-robin multi-lane grant, registered CDB lanes, flush support.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 6,
  parameter int unsigned NUM_LANES = NUM_CDB_INPUTS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fls_i,
  cdb_arbiter_if.slave       bus
);

  localparam int unsigned SRC_W = idx_w(NUM_REQ);
  localparam int unsigned PTR_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]                 hold_vld_q;
  cdb_result_t [NUM_REQ-1:0]          hold_q;
  logic [PTR_W-1:0]                   rr_ptr_q;
  common_data_bus_t                   lane_q;
  logic [NUM_LANES-1:0][SRC_W-1:0]    lane_src_q;

  logic [NUM_REQ-1:0]                 grant_c;
  logic [NUM_REQ-1:0]                 rdy_c;
  logic [NUM_REQ-1:0]                 acc_c;
  logic [NUM_LANES-1:0][NUM_REQ-1:0]  lane_sel_c;
  logic [NUM_LANES-1:0]               lane_gnt_c;
  logic [PTR_W-1:0]                   nxt_ptr_c;
  cdb_result_t [NUM_LANES-1:0]        lane_res_c;
  logic [NUM_LANES-1:0][SRC_W-1:0]    lane_src_c;

  cdb_arbiter_rr_multi_grant #(
    .NUM_REQ   (NUM_REQ),
    .NUM_LANES (NUM_LANES)
  ) u_grant (
    .req        (hold_vld_q),
    .ptr        (rr_ptr_q),
    .grant_c    (grant_c),
    .lane_sel_c (lane_sel_c),
    .lane_vld_c (lane_gnt_c),
    .nxt_ptr_c  (nxt_ptr_c)
  );

  // A slot can take a new result if empty or draining this cycle; never during reset/flush.
  always_comb begin
    rdy_c = (rst || fls_i) ? '0 : (~hold_vld_q | grant_c);
    acc_c = bus.req_vld_i & rdy_c;
  end

  // Steer each granted holding register onto its lane.
  always_comb begin
    lane_res_c = '0;
    lane_src_c = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (lane_sel_c[k][i]) begin
          lane_res_c[k] = hold_q[i];
          lane_src_c[k] = SRC_W'(i);
        end
      end
    end
  end

  // Holding registers, lane registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q <= '0;
      hold_q     <= '0;
      rr_ptr_q   <= '0;
      lane_q     <= '0;
      lane_src_q <= '0;
    end else if (fls_i) begin
      hold_vld_q <= '0;
      for (int unsigned k = 0; k < NUM_LANES; k++) lane_q.data_lanes[k].vld <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (acc_c[i]) begin
          hold_vld_q[i] <= 1'b1;
          hold_q[i]     <= '{rob: bus.req_rob_i[i], data: bus.req_data_i[i]};
        end else if (grant_c[i]) begin
          hold_vld_q[i] <= 1'b0;
        end
      end
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        lane_q.data_lanes[k].vld    <= lane_gnt_c[k];
        lane_q.data_lanes[k].result <= lane_res_c[k];
        lane_src_q[k]               <= lane_src_c[k];
      end
      rr_ptr_q <= nxt_ptr_c;
    end
  end

  // Drive the bus; a flush suppresses the broadcast already in flight.
  always_comb begin
    bus.req_rdy_o   = rdy_c;
    bus.lane_vld_o  = '0;
    bus.lane_rob_o  = '0;
    bus.lane_data_o = '0;
    bus.lane_src_o  = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      bus.lane_vld_o[k]  = lane_q.data_lanes[k].vld & ~fls_i;
      bus.lane_rob_o[k]  = lane_q.data_lanes[k].result.rob;
      bus.lane_data_o[k] = lane_q.data_lanes[k].result.data;
      bus.lane_src_o[k]  = lane_src_q[k];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic against a
// queue-based reference model, checked by a separate scoreboard monitor.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 6;
  localparam int L  = 2;
  localparam int RW = ROB_IDX_LEN;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst;
  logic fls;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N), .NUM_LANES(L)) bus ();

  cdb_arbiter #(.NUM_REQ(N), .NUM_LANES(L)) dut (
    .clk   (clk),
    .rst   (rst),
    .fls_i (fls),
    .bus   (bus)
  );

  typedef struct {
    bit                      in_rst;
    logic [N-1:0]            rdy;
    logic [L-1:0]            vld;
    logic [L-1:0][RW-1:0]    rob;
    logic [L-1:0][31:0]      data;
    logic [L-1:0][SW-1:0]    src;
  } exp_t;

  exp_t         sbq[$];
  int           total = 0;
  int           bad   = 0;
  int           rob_ctr = 0;
  logic [N-1:0] last_rdy;
  logic [N-1:0] pend;

  logic [RW-1:0] o_rob [N];
  logic [31:0]   o_dat [N];

  // Reference model state: held results, pointer, results currently on the lanes.
  bit            m_hv [N];
  logic [RW-1:0] m_hr [N];
  logic [31:0]   m_hd [N];
  int            m_ptr;
  int            m_ln;
  int            m_ls [L];
  logic [RW-1:0] m_lr [L];
  logic [31:0]   m_ld [L];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, predict what the DUT shows this cycle, advance the model.
  task automatic cycle(input logic [N-1:0] v, input logic f, input logic r);
    exp_t         e;
    int           gl[$];
    logic [N-1:0] g;
    @(posedge clk); #1;
    rst = r;
    fls = f;
    bus.req_vld_i = v;
    for (int i = 0; i < N; i++) begin
      bus.req_rob_i[i]  = o_rob[i];
      bus.req_data_i[i] = o_dat[i];
    end
    e.in_rst = r;
    e.rdy = '0; e.vld = '0; e.rob = '0; e.data = '0; e.src = '0;
    if (r) begin
      for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
      m_ln  = 0;
      m_ptr = 0;
    end else begin
      // Oldest-in-rotation first: list held requesters starting at the pointer.
      for (int off = 0; off < N; off++) begin
        int idx;
        idx = (m_ptr + off) % N;
        if (m_hv[idx] && gl.size() < L) gl.push_back(idx);
      end
      g = '0;
      foreach (gl[k]) g[gl[k]] = 1'b1;
      for (int i = 0; i < N; i++) e.rdy[i] = !f && (!m_hv[i] || g[i]);
      if (!f) begin
        for (int k = 0; k < m_ln; k++) begin
          e.vld[k]  = 1'b1;
          e.rob[k]  = m_lr[k];
          e.data[k] = m_ld[k];
          e.src[k]  = SW'(m_ls[k]);
        end
      end
      if (f) begin
        for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
        m_ln = 0;
      end else begin
        m_ln = gl.size();
        foreach (gl[k]) begin
          m_ls[k] = gl[k];
          m_lr[k] = m_hr[gl[k]];
          m_ld[k] = m_hd[gl[k]];
        end
        for (int i = 0; i < N; i++) begin
          if (v[i] && e.rdy[i]) begin
            m_hv[i] = 1'b1;
            m_hr[i] = o_rob[i];
            m_hd[i] = o_dat[i];
          end else if (g[i]) begin
            m_hv[i] = 1'b0;
          end
        end
        if (gl.size() > 0) m_ptr = (gl[gl.size()-1] + 1) % N;
      end
    end
    last_rdy = e.rdy;
    sbq.push_back(e);
  endtask

  task automatic new_offer(input int i);
    o_rob[i] = RW'(rob_ctr);
    o_dat[i] = $urandom;
    rob_ctr  = (rob_ctr + 1) % 32;
  endtask

  // Random traffic; an offer not taken stays stable until accepted or flushed.
  task automatic run_random(input int ncyc, input logic [N-1:0] mask, input int pct,
                            input int fpct, input int rpct, input bit trk);
    logic [N-1:0] v;
    logic         f, r;
    int           low, maxlow;
    low = 0; maxlow = 0;
    for (int c = 0; c < ncyc; c++) begin
      f = ($urandom_range(99) < fpct);
      r = ($urandom_range(99) < rpct);
      for (int i = 0; i < N; i++) begin
        if (pend[i]) v[i] = 1'b1;
        else if (mask[i] && ($urandom_range(99) < pct)) begin
          v[i] = 1'b1;
          new_offer(i);
        end else v[i] = 1'b0;
      end
      cycle(v, f, r);
      for (int i = 0; i < N; i++) pend[i] = v[i] && !last_rdy[i] && !f;
      if (trk) begin
        @(negedge clk);
        if (v[1] && !bus.req_rdy_o[1]) low++;
        else low = 0;
        if (low > maxlow) maxlow = low;
      end
    end
    if (trk) begin
      total++;
      if (maxlow > 2) begin
        bad++;
        $display("FAIL req1_wait act=%0d exp<=2", maxlow);
      end
    end
  endtask

  // Scoreboard monitor: pop the prediction for this cycle and compare mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        exp_t e;
        e = sbq.pop_front();
        total++;
        if (bus.req_rdy_o !== e.rdy) begin
          bad++;
          $display("FAIL rdy act=%b exp=%b t=%0t", bus.req_rdy_o, e.rdy, $time);
        end
        if (!e.in_rst) begin
          total++;
          if (bus.lane_vld_o !== e.vld) begin
            bad++;
            $display("FAIL lane_vld act=%b exp=%b t=%0t", bus.lane_vld_o, e.vld, $time);
          end
          for (int k = 0; k < L; k++) begin
            if (e.vld[k]) begin
              total++;
              if ({bus.lane_rob_o[k], bus.lane_data_o[k], bus.lane_src_o[k]} !==
                  {e.rob[k], e.data[k], e.src[k]}) begin
                bad++;
                $display("FAIL lane%0d act=rob%0d/%h/src%0d exp=rob%0d/%h/src%0d t=%0t", k,
                         bus.lane_rob_o[k], bus.lane_data_o[k], bus.lane_src_o[k],
                         e.rob[k], e.data[k], e.src[k], $time);
              end
            end
          end
          for (int a = 0; a < L; a++) begin
            for (int b = a + 1; b < L; b++) begin
              if (bus.lane_vld_o[a] && bus.lane_vld_o[b]) begin
                total++;
                if (bus.lane_rob_o[a] == bus.lane_rob_o[b]) begin
                  bad++;
                  $display("FAIL dup_rob act=%0d on lanes %0d,%0d exp=distinct", bus.lane_rob_o[a], a, b);
                end
              end
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    fls = 1'b0;
    bus.req_vld_i  = '0;
    bus.req_rob_i  = '0;
    bus.req_data_i = '0;
    pend = '0;
    m_ptr = 0; m_ln = 0;
    for (int i = 0; i < N; i++) begin
      o_rob[i] = '0; o_dat[i] = '0;
      m_hv[i] = 1'b0; m_hr[i] = '0; m_hd[i] = '0;
    end
    for (int k = 0; k < L; k++) begin
      m_ls[k] = 0; m_lr[k] = '0; m_ld[k] = '0;
    end

    // Reset then idle.
    cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_rdy", 64'(bus.req_rdy_o), 64'h3f);
    chk("idle_lane_vld", 64'(bus.lane_vld_o), 64'h0);
    cycle('0, 1'b0, 1'b0);

    // Single result from requester 3: visible two cycles after the handshake, once.
    o_rob[3] = RW'(5);
    o_dat[3] = 32'hDEADBEEF;
    cycle(6'b001000, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    @(negedge clk);
    chk("single_early", 64'(bus.lane_vld_o), 64'h0);
    cycle('0, 1'b0, 1'b0);
    @(negedge clk);
    chk("single_vld", 64'(bus.lane_vld_o), 64'h1);
    chk("single_rob", 64'(bus.lane_rob_o[0]), 64'd5);
    chk("single_data", 64'(bus.lane_data_o[0]), 64'hDEADBEEF);
    chk("single_src", 64'(bus.lane_src_o[0]), 64'd3);
    cycle('0, 1'b0, 1'b0);
    @(negedge clk);
    chk("single_once", 64'(bus.lane_vld_o), 64'h0);

    // All six held with pointer at 0: pairs {0,1},{2,3},{4,5}.
    cycle('0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      o_rob[i] = RW'(16 + i);
      o_dat[i] = $urandom;
    end
    cycle(6'h3f, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      cycle('0, 1'b0, 1'b0);
      @(negedge clk);
      chk("rr_vld", 64'(bus.lane_vld_o), 64'h3);
      chk("rr_src0", 64'(bus.lane_src_o[0]), 64'(2 * s));
      chk("rr_src1", 64'(bus.lane_src_o[1]), 64'(2 * s + 1));
    end
    cycle('0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rr_drained", 64'(bus.lane_vld_o), 64'h0);

    // Requester 1 streams against 2..5; its wait stays bounded.
    pend = '0;
    run_random(24, 6'b111110, 100, 0, 0, 1'b1);
    run_random(8, 6'b000000, 0, 0, 0, 1'b0);

    // Flush while lanes carry rob 7/9 and four more results are held.
    cycle('0, 1'b0, 1'b1);
    o_rob[0] = RW'(7);
    o_rob[1] = RW'(9);
    cycle(6'b000011, 1'b0, 1'b0);
    for (int i = 2; i < N; i++) o_rob[i] = RW'(18 + i);
    cycle(6'b111100, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fls_lane_vld", 64'(bus.lane_vld_o), 64'h0);
    chk("fls_rdy", 64'(bus.req_rdy_o), 64'h0);
    cycle('0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_fls_lane_vld", 64'(bus.lane_vld_o), 64'h0);
    chk("post_fls_rdy", 64'(bus.req_rdy_o), 64'h3f);
    for (int c = 0; c < 4; c++) cycle('0, 1'b0, 1'b0);

    // Reset with five held results and both lanes valid.
    cycle('0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) o_rob[i] = RW'(24 + i);
    cycle(6'h3f, 1'b0, 1'b0);
    o_rob[0] = RW'(30);
    cycle(6'b000001, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rst_mid_rdy", 64'(bus.req_rdy_o), 64'h0);
    cycle('0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_mid_lane_vld", 64'(bus.lane_vld_o), 64'h0);
    chk("rst_mid_rdy_after", 64'(bus.req_rdy_o), 64'h3f);
    for (int c = 0; c < 4; c++) cycle('0, 1'b0, 1'b0);

    // Random mix including occasional flush and reset.
    pend = '0;
    run_random(600, 6'h3f, 40, 3, 1, 1'b0);
    run_random(4, 6'h00, 0, 0, 0, 1'b0);

    cycle('0, 1'b0, 1'b0);
    @(negedge clk); #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain act=%0d exp=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
